mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester (iREN/iaddr) and the data requester (dREN/dWEN/daddr/dstore) driven by the control unit.
- Fixed data-over-instruction priority; one access in flight at a time.
- Returns one-cycle ihit/dhit pulses with load data, and bounds every access with a wait-state watchdog so the CPU never hangs on a stalled or erroring RAM.

Parameters:
- MAX_WAIT, 16, cycles an access may remain un-acknowledged (no ACCESS) before it is aborted; legal range 2..255.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- halt  in  1  CPU halt; blocks new instruction grants
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- ihit  out  1  instruction access complete (1-cycle pulse)
- iload  out  32  instruction data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dhit  out  1  data access complete (1-cycle pulse)
- dload  out  32  data read value
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
- err_timeout  out  1  sticky: watchdog abort occurred
- err_ram  out  1  sticky: ramstate ERROR seen
- err_proto  out  1  sticky: dREN and dWEN sampled high together at grant

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, latched addr/data/wen=0, and every output=0, including iload, dload and all err_* flags.
- States: IDLE, IACC, DACC.
- IDLE transitions, evaluated each rising edge:
  - If dREN|dWEN, go to DACC and latch daddr, dstore and wen=dWEN.
  - Else if iREN & !halt, go to IACC and latch iaddr.
  - Else stay in IDLE.
- Grant latches inputs; later input changes do not affect the access in flight.
- Both dREN and dWEN at grant: treated as a write; err_proto set.
- RAM drive:
  - In IACC/DACC: ramaddr=latched addr.
  - In IACC: ramREN=1.
  - In DACC: ramREN=!wen, ramWEN=wen, ramstore=latched data.
  - In IDLE: all RAM outputs 0.
- Completion: in IACC/DACC, a cycle with ramstate==ACCESS completes the access.
  - The matching hit is asserted combinationally in that same cycle.
  - The matching load output equals ramload in that cycle and is registered at that edge.
  - Next state is IDLE.
- Minimum latency: request visible in cycle 0 → RAM strobes in cycle 1 → earliest hit in cycle 1.
- One mandatory IDLE cycle follows every completion, so the requester's still-high request is not re-granted.
- Load outputs hold their last captured value outside hit cycles; writes do not update dload.
- Watchdog:
  - Counter clears on grant and increments each IACC/DACC cycle without ACCESS.
  - When the count reaches MAX_WAIT: matching hit=1, load=32'hBAD1BAD1 (registered), err_timeout set, next state IDLE.
- ramstate==ERROR in IACC/DACC: same abort action, sets err_ram instead. ERROR takes precedence over timeout in the same cycle.
- ramstate FREE/BUSY: keep waiting.
- No abort on request withdrawal: a requester that drops its request mid-access still receives the hit pulse.
- halt:
  - Asserted during IACC: the fetch in flight completes normally.
  - While halt is high, data requests are still granted; instruction requests are not.
- err_* flags are cleared only by nRST.
- Reset mid-access drops all strobes immediately; no hit is produced.
- ihit and dhit are never high in the same cycle.

Test Plan:
- Read: iREN=1, iaddr=0x40, ramstate=ACCESS on first strobe cycle with ramload=0x3C010001 → ramREN=1 in cycle 1, ihit pulse in cycle 1, iload=0x3C010001 held after; IDLE in cycle 2.
- Contention: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) in the same cycle → DACC granted first with ramWEN=1 and ramstore=0xDEADBEEF; dhit pulse; after the IDLE bubble, IACC with ihit.
- Wait states: dREN=1, ramstate=BUSY for 3 cycles then ACCESS with ramload=0x1234 → dhit in cycle 4, dload=0x1234, err flags stay 0.
- Timeout: MAX_WAIT=16, iREN=1, ramstate stuck BUSY → ihit after 16 strobe cycles, iload=0xBAD1BAD1, err_timeout=1 and remains 1 until nRST.
- Error and protocol violation: dREN=dWEN=1 with ramstate=ERROR → ramWEN=1, dhit pulse, err_proto=1 and err_ram=1.
- Halt and reset: halt=1 with iREN=1 → no grant and no strobes; nRST pulled low mid-DACC → all outputs 0 asynchronously and no dhit.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU requesters, the RAM port and the arbiter.
// slave is the arbiter's view. master is the view of whoever drives the
// requesters and the RAM.
interface mem_arbiter_if;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err_timeout;
  logic        err_ram;
  logic        err_proto;

  modport slave (
    input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore,
           err_timeout, err_ram, err_proto
  );

  modport master (
    output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore,
           err_timeout, err_ram, err_proto
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter. The data requester always wins over instruction
// fetch, and only one access is in flight at a time. A wait-state watchdog
// aborts any access that the RAM never acknowledges.
module mem_arbiter #(
  parameter int unsigned MAX_WAIT = 16  // legal range 2..255
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_e;

  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [31:0] ABORT_WORD = 32'hBAD1_BAD1;
  // The count reaches MAX_WAIT in the cycle where wait_q holds MAX_WAIT-1.
  localparam logic [7:0]  WAIT_LAST  = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        wen_q, wen_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_ram_q, err_ram_d;
  logic        err_proto_q, err_proto_d;

  logic busy, ram_ok, ram_err, timeout, done, grant_d, grant_i;
  logic [31:0] load_word;

  // Decode the RAM response and the grant conditions for this cycle.
  always_comb begin
    busy      = (state_q != IDLE);
    ram_ok    = busy && (bus.ramstate == RAM_ACCESS);
    ram_err   = busy && (bus.ramstate == RAM_ERROR);
    timeout   = busy && !ram_ok && !ram_err && (wait_q == WAIT_LAST);
    done      = ram_ok || ram_err || timeout;
    grant_d   = (state_q == IDLE) && (bus.dREN || bus.dWEN);
    grant_i   = (state_q == IDLE) && !grant_d && bus.iREN && !bus.halt;
    load_word = ram_ok ? bus.ramload : ABORT_WORD;
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: data before instruction; always return to IDLE after an
  // access so a still-high request sees one bubble before regrant.
  always_comb begin
    // NOTE: default-assign first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (grant_d)      state_d = DACC;
                  else if (grant_i) state_d = IACC;
      IACC, DACC: if (done)         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Outputs: RAM strobes from the latched request, hits on completion.
  always_comb begin
    bus.ihit        = (state_q == IACC) && done;
    bus.dhit        = (state_q == DACC) && done;
    bus.ramREN      = (state_q == IACC) || ((state_q == DACC) && !wen_q);
    bus.ramWEN      = (state_q == DACC) && wen_q;
    bus.ramaddr     = busy ? addr_q : 32'h0;
    bus.ramstore    = (state_q == DACC) ? data_q : 32'h0;
    bus.iload       = iload_q;
    bus.dload       = dload_q;
    bus.err_timeout = err_timeout_q;
    bus.err_ram     = err_ram_q;
    bus.err_proto   = err_proto_q;
  end

  // Datapath next values: request latch, watchdog, load capture, sticky flags.
  always_comb begin
    addr_d        = addr_q;
    data_d        = data_q;
    wen_d         = wen_q;
    wait_d        = wait_q;
    iload_d       = iload_q;
    dload_d       = dload_q;
    err_timeout_d = err_timeout_q | timeout;
    err_ram_d     = err_ram_q | ram_err;
    err_proto_d   = err_proto_q;
    if (grant_d) begin
      addr_d      = bus.daddr;
      data_d      = bus.dstore;
      wen_d       = bus.dWEN;   // both strobes high resolves to a write
      wait_d      = 8'd0;
      err_proto_d = err_proto_q | (bus.dREN & bus.dWEN);
    end else if (grant_i) begin
      addr_d = bus.iaddr;
      data_d = 32'h0;
      wen_d  = 1'b0;
      wait_d = 8'd0;
    end else if (busy && !done) begin
      wait_d = wait_q + 8'd1;
    end
    if (bus.ihit)           iload_d = load_word;
    if (bus.dhit && !wen_q) dload_d = load_word;
  end

  // Datapath registers.
  // NOTE: every register here is reset, including the load holding
  // registers, so outputs are defined from the first cycle after reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      wen_q         <= 1'b0;
      wait_q        <= 8'd0;
      iload_q       <= 32'h0;
      dload_q       <= 32'h0;
      err_timeout_q <= 1'b0;
      err_ram_q     <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      data_q        <= data_d;
      wen_q         <= wen_d;
      wait_q        <= wait_d;
      iload_q       <= iload_d;
      dload_q       <= dload_d;
      err_timeout_q <= err_timeout_d;
      err_ram_q     <= err_ram_d;
      err_proto_q   <= err_proto_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Each access is predicted at
// transaction level: who wins, how many strobe cycles it lasts, what word
// it returns and which sticky flags it raises.
module tb_mem_arbiter;
  localparam int MAX_WAIT = 16;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
  localparam logic [31:0] ABORT = 32'hBAD1BAD1;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (.CLK(clk), .nRST(nrst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic        exp_tmo, exp_ram, exp_proto;
  logic [31:0] exp_iload, exp_dload;

  task automatic model_reset();
    exp_tmo = 0; exp_ram = 0; exp_proto = 0;
    exp_iload = 32'h0; exp_dload = 32'h0;
  endtask

  task automatic clear_inputs();
    bus.halt = 0; bus.iREN = 0; bus.iaddr = 0;
    bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = FREE;
  endtask

  // One arbitration round. Cycle 0 presents the request in IDLE, then the
  // predicted number of strobe cycles follow. hold=0 withdraws requests
  // and scrambles the request buses during the access.
  task automatic xfer(input logic ireq, input logic dren, input logic dwen,
                      input logic hlt, input logic [31:0] ia,
                      input logic [31:0] da, input logic [31:0] ds,
                      input int n_busy, input logic [1:0] fs,
                      input logic [31:0] ld, input bit hold);
    int          kind;   // 0 none, 1 instruction, 2 data
    int          lat;
    bit          ok, rerr;
    logic [31:0] word, eaddr;
    logic [1:0]  ehit;
    kind  = (dren | dwen) ? 2 : ((ireq && !hlt) ? 1 : 0);
    eaddr = (kind == 2) ? da : ia;
    ok    = (fs == ACC) && (n_busy < MAX_WAIT);
    rerr  = (fs == ERR) && (n_busy < MAX_WAIT);
    lat   = (ok || rerr) ? n_busy + 1 : MAX_WAIT;
    word  = ok ? ld : ABORT;

    @(negedge clk);
    bus.iREN = ireq; bus.dREN = dren; bus.dWEN = dwen; bus.halt = hlt;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    bus.ramstate = 2'($urandom_range(0, 3)); bus.ramload = $urandom;
    #1;
    checks++;
    if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ihit, bus.dhit} !== 68'h0) begin
      errors++;
      $display("FAIL idle_outputs: ren=%b wen=%b addr=%h store=%h ihit=%b dhit=%b, required all 0",
               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ihit, bus.dhit);
    end
    checks++;
    if ({bus.iload, bus.dload} !== {exp_iload, exp_dload}) begin
      errors++;
      $display("FAIL held_loads: iload=%h dload=%h, required %h %h",
               bus.iload, bus.dload, exp_iload, exp_dload);
    end
    checks++;
    if ({bus.err_timeout, bus.err_ram, bus.err_proto} !== {exp_tmo, exp_ram, exp_proto}) begin
      errors++;
      $display("FAIL err_flags: tmo/ram/proto=%b%b%b, required %b%b%b",
               bus.err_timeout, bus.err_ram, bus.err_proto, exp_tmo, exp_ram, exp_proto);
    end

    if (kind == 0) begin
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk); #1;
        checks++;
        if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit} !== 4'b0) begin
          errors++;
          $display("FAIL no_grant: ren=%b wen=%b ihit=%b dhit=%b, required 0",
                   bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit);
        end
      end
      return;
    end

    if (kind == 2 && dren && dwen) exp_proto = 1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (!hold) begin
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.halt = 1'($urandom_range(0, 1));
        bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
      end
      bus.ramstate = (k <= n_busy) ? 2'($urandom_range(0, 1)) : fs;
      bus.ramload  = (k == lat) ? ld : $urandom;
      #1;
      checks++;
      if ({bus.ramREN, bus.ramWEN} !== ((kind == 1) ? 2'b10 : (dwen ? 2'b01 : 2'b10))) begin
        errors++;
        $display("FAIL strobes cyc%0d: ren=%b wen=%b, kind=%0d write=%b",
                 k, bus.ramREN, bus.ramWEN, kind, dwen);
      end
      checks++;
      if (bus.ramaddr !== eaddr) begin
        errors++;
        $display("FAIL ramaddr cyc%0d: got %h, required %h", k, bus.ramaddr, eaddr);
      end
      if (kind == 2) begin
        checks++;
        if (bus.ramstore !== ds) begin
          errors++;
          $display("FAIL ramstore cyc%0d: got %h, required %h", k, bus.ramstore, ds);
        end
      end
      ehit = (k != lat) ? 2'b00 : ((kind == 1) ? 2'b10 : 2'b01);
      checks++;
      if ({bus.ihit, bus.dhit} !== ehit) begin
        errors++;
        $display("FAIL hit cyc%0d/%0d: ihit=%b dhit=%b, required %b",
                 k, lat, bus.ihit, bus.dhit, ehit);
      end
    end
    if (kind == 1) exp_iload = word;
    if (kind == 2 && !dwen) exp_dload = word;
    if (!ok && !rerr) exp_tmo = 1;
    if (rerr) exp_ram = 1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.iREN = 1; bus.dREN = 1; bus.dWEN = 1; bus.ramstate = ACC;
    bus.ramload = 32'h1111_2222; bus.iaddr = 32'h10; bus.daddr = 32'h20;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ihit, bus.dhit,
         bus.iload, bus.dload, bus.err_timeout, bus.err_ram, bus.err_proto} !== 135'h0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero (ren=%b wen=%b addr=%h iload=%h dload=%h)",
               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.iload, bus.dload);
    end
    @(negedge clk);
    clear_inputs();
    nrst = 1;
  endtask

  task automatic test_read();
    xfer(1, 0, 0, 0, 32'h40, 0, 0, 0, ACC, 32'h3C010001, 0);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, ACC, 0, 0);
  endtask

  task automatic test_contention();
    xfer(1, 0, 1, 0, 32'h200, 32'h100, 32'hDEADBEEF, 0, ACC, 32'h0, 1);
    xfer(1, 0, 0, 0, 32'h200, 0, 0, 0, ACC, 32'hCAFE0001, 0);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, ACC, 0, 0);
  endtask

  task automatic test_wait_states();
    xfer(0, 1, 0, 0, 0, 32'h80, 0, 3, ACC, 32'h1234, 0);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, ACC, 0, 0);
  endtask

  task automatic test_timeout();
    xfer(1, 0, 0, 0, 32'h44, 0, 0, MAX_WAIT, BUSY, 0, 1);
    xfer(0, 1, 0, 0, 0, 32'h48, 0, MAX_WAIT - 1, ACC, 32'h5A5A0000, 0);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, ACC, 0, 0);
  endtask

  task automatic test_error_proto();
    xfer(0, 1, 1, 0, 0, 32'h300, 32'h55, 0, ERR, 0, 0);
    xfer(0, 1, 0, 0, 0, 32'h304, 0, 2, ERR, 32'h77, 0);
    xfer(0, 0, 0, 0, 0, 0, 0, 0, ACC, 0, 0);
  endtask

  task automatic test_halt_reset();
    xfer(1, 0, 0, 1, 32'h60, 0, 0, 0, ACC, 0, 1);
    xfer(1, 1, 0, 1, 32'h60, 32'h64, 0, 1, ACC, 32'h0BADF00D, 0);
    xfer(1, 0, 0, 0, 32'h68, 0, 0, 2, ACC, 32'h600D0001, 0);
    // Reset in the middle of a data write.
    @(negedge clk);
    clear_inputs();
    bus.dWEN = 1; bus.daddr = 32'h400; bus.dstore = 32'h99;
    @(negedge clk);
    bus.dWEN = 0; bus.ramstate = BUSY;
    #1;
    checks++;
    if (bus.ramWEN !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_write: ramWEN=%b, required 1", bus.ramWEN);
    end
    #1;
    nrst = 0;
    bus.ramstate = ACC;
    #1;
    model_reset();
    checks++;
    if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.ihit, bus.dhit,
         bus.iload, bus.dload, bus.err_timeout, bus.err_ram, bus.err_proto} !== 135'h0) begin
      errors++;
      $display("FAIL mid_access_reset: ren=%b wen=%b addr=%h dhit=%b flags=%b%b%b, required all 0",
               bus.ramREN, bus.ramWEN, bus.ramaddr, bus.dhit,
               bus.err_timeout, bus.err_ram, bus.err_proto);
    end
    @(negedge clk);
    clear_inputs();
    nrst = 1;
    xfer(0, 0, 0, 0, 0, 0, 0, 0, ACC, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [1:0] fs;
      case ($urandom_range(0, 3))
        0:       fs = ERR;
        1:       fs = BUSY;
        default: fs = ACC;
      endcase
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
           int'($urandom_range(0, MAX_WAIT + 2)), fs, $urandom, 1'($urandom_range(0, 1)));
    end
    xfer(0, 0, 0, 0, 0, 0, 0, 0, ACC, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_read();
    test_contention();
    test_wait_states();
    test_timeout();
    test_error_proto();
    test_halt_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
